regwb_arbiter: RTL and testbench
================================

# regwb_arbiter

Write-back arbiter and register scoreboard for the MIPS register file. Shares the register file's single write port between the ALU write-back path (requester A) and the load unit (requester B) through valid/ready handshakes, and registers the winning write onto regWrite/W_reg/W_data. Keeps one busy bit per register so the issue stage stalls on RAW/WAW hazards against writes still in flight. Sits between the execute/memory stages and the register file.

## Interface
- NREG, 32, number of architectural registers; index width fixed at 5 bits.
- DW, 32, write-data width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_valid  in  1  ALU write request.
- a_ready  out  1  ALU request granted this cycle.
- a_reg  in  5  ALU destination register.
- a_data  in  DW  ALU write data.
- b_valid  in  1  load-unit write request.
- b_ready  out  1  load request granted this cycle.
- b_reg  in  5  load destination register.
- b_data  in  DW  load write data.
- regWrite  out  1  register-file write enable (registered).
- W_reg  out  5  register-file write index (registered).
- W_data  out  DW  register-file write data (registered).
- iss_valid  in  1  issue stage presents an instruction.
- iss_dst  in  5  its destination register.
- iss_src1, iss_src2  in  5 each  its source registers.
- iss_stall  out  1  instruction must not issue this cycle.
- busy_vec  out  NREG  pending-write bit per register.
- sb_err  out  1  sticky: write arrived for a non-busy register.

## Operation
- Handshake: transfer when x_valid && x_ready. Ready is combinational from valids and arbitration state; at most one of a_ready/b_ready is high per cycle. Requesters hold reg/data stable while valid and not ready.
- Arbitration with only one valid: that requester is granted. With both valid: see Configuration.
- Output stage: on a handshake edge, W_reg/W_data load the winner's fields; regWrite = 1 for exactly the next cycle unless the destination is 0. No handshake leaves regWrite = 0, W_reg/W_data hold.
- Register 0: writes are accepted (ready high, handshake completes) but regWrite stays 0; busy_vec[0] is never set; register 0 never causes a stall.
- Scoreboard: an instruction issues when iss_valid && !iss_stall; at that edge busy_vec[iss_dst] sets (dst ≠ 0).
- iss_stall = iss_valid && (busy[iss_src1] || busy[iss_src2] || busy[iss_dst]); source/destination 0 is ignored. iss_stall = 0 when iss_valid = 0.
- Clear: busy_vec[W_reg] clears on the edge ending the regWrite = 1 cycle (the edge the register file commits the data).
- Same register set by issue and cleared in the same edge: set wins.
- Handshake to a register whose busy bit is 0 (dst ≠ 0): write still performed, sb_err set and held until reset.

## Timing
- Reset (rst = 0, asynchronous): regWrite = 0, W_reg = 0, W_data = 0, busy_vec = 0, sb_err = 0, round-robin pointer = "B granted last"; a_ready/b_ready/iss_stall follow the combinational rules using cleared state. Reset mid-transfer discards the in-flight write (regWrite drops immediately).
- Handshake at edge N → regWrite = 1 during cycle N..N+1 → register file written and busy bit cleared at edge N+1 → dependent instruction can issue in cycle after N+1, reading the new value combinationally.
- Throughput: one write per cycle, back-to-back.

## Configuration
- WB_RR_EN defined: round-robin. Pointer records last granted requester, updated on every handshake; with both valid, the requester not granted last wins. First contested grant after reset goes to A.
- WB_RR_EN undefined: fixed priority, B (load) always beats A; pointer logic absent.

## Test plan
- Reset then single A write: a_valid = 1, a_reg = 5, a_data = 0xDEADBEEF → a_ready = 1 same cycle; next cycle regWrite = 1, W_reg = 5, W_data = 0xDEADBEEF; then regWrite = 0.
- Contention, WB_RR_EN on: both valid for 4 cycles (A reg 1, B reg 2) → grants A, B, A, B; regWrite high 4 consecutive cycles. Macro off → B granted all 4, a_ready = 0 throughout.
- RAW stall: issue dst = 7; next cycle iss_src1 = 7 → iss_stall = 1; B writes reg 7 → iss_stall drops in the cycle after the regWrite cycle.
- Register 0: A writes reg 0 with 0x1234 → a_ready = 1, regWrite stays 0; issue dst = 0 → busy_vec unchanged, no stall.
- Simultaneous set/clear on reg 9 at the same edge → busy_vec[9] = 1 afterwards; stray write to non-busy reg 3 → sb_err = 1, held.
- Assert rst low during a regWrite = 1 cycle with busy_vec = 0x0000_0080 → regWrite, busy_vec, sb_err go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/regwb_if.sv
// regwb_if: bus bundle for the register-file write-back arbiter.
// Carries both write requesters (A = ALU, B = load unit), the registered
// register-file write port, and the issue-stage scoreboard query.
//   master : the surrounding pipeline (drives requests and the issue query)
//   slave  : regwb_arbiter (drives readies, the write port and scoreboard status)
// Parameters: NREG registers (5-bit index), DW data bits.
interface regwb_if #(
  parameter int NREG = 32,
  parameter int DW   = 32
);
  logic          a_valid;
  logic          a_ready;
  logic [4:0]    a_reg;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_reg;
  logic [DW-1:0] b_data;
  logic          regWrite;
  logic [4:0]    W_reg;
  logic [DW-1:0] W_data;
  logic          iss_valid;
  logic [4:0]    iss_dst;
  logic [4:0]    iss_src1;
  logic [4:0]    iss_src2;
  logic          iss_stall;
  logic [NREG-1:0] busy_vec;
  logic          sb_err;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
           iss_valid, iss_dst, iss_src1, iss_src2,
    input  a_ready, b_ready, regWrite, W_reg, W_data, iss_stall, busy_vec, sb_err
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
           iss_valid, iss_dst, iss_src1, iss_src2,
    output a_ready, b_ready, regWrite, W_reg, W_data, iss_stall, busy_vec, sb_err
  );
endinterface

// File: rtl/regwb_arbiter.sv
// regwb_arbiter: shares the register file's single write port between the
// ALU write-back path (A) and the load unit (B), and keeps a busy bit per
// register so the issue stage stalls on RAW/WAW hazards.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - regwb_if.slave: request handshakes, registered write port
//          (regWrite/W_reg/W_data), issue query (iss_*), busy_vec, sb_err
// Build option: define WB_RR_EN for round-robin arbitration between A and B;
// without it B (load) has fixed priority over A.
module regwb_arbiter #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic    clk,
  input  logic    rst,
  regwb_if.slave  bus
);

  logic            a_rdy;
  logic            b_rdy;
  logic            hs;
  logic            a_wins_tie;
  logic [4:0]      win_reg;
  logic [DW-1:0]   win_data;
  logic            vld_p1;
  logic [4:0]      reg_p1;
  logic [DW-1:0]   data_p1;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic            sb_err_q;
  logic            stall;
  logic            issue;

`ifdef WB_RR_EN
  // 1 = B was granted last; reset value makes the first contested grant go to A.
  logic last_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b <= 1'b1;
    end else if (hs) begin
      last_b <= b_rdy;
    end
  end

  assign a_wins_tie = last_b;
`else
  assign a_wins_tie = 1'b0;
`endif

  always_comb begin
    a_rdy    = bus.a_valid && (!bus.b_valid || a_wins_tie);
    b_rdy    = bus.b_valid && (!bus.a_valid || !a_wins_tie);
    hs       = a_rdy || b_rdy;
    win_reg  = a_rdy ? bus.a_reg  : bus.b_reg;
    win_data = a_rdy ? bus.a_data : bus.b_data;
  end

  // Register 0 never counts as busy, so it never stalls issue.
  always_comb begin
    stall = 1'b0;
    if (bus.iss_valid) begin
      stall = ((bus.iss_src1 != 5'd0) && busy_q[bus.iss_src1]) ||
              ((bus.iss_src2 != 5'd0) && busy_q[bus.iss_src2]) ||
              ((bus.iss_dst  != 5'd0) && busy_q[bus.iss_dst]);
    end
    issue = bus.iss_valid && !stall;
  end

  // Clear first, then set: an issue to the register being committed this
  // edge keeps it busy.
  always_comb begin
    busy_nxt = busy_q;
    if (vld_p1) begin
      busy_nxt[reg_p1] = 1'b0;
    end
    if (issue && (bus.iss_dst != 5'd0)) begin
      busy_nxt[bus.iss_dst] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // ---- stage p1: registered write port and scoreboard state ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      reg_p1   <= 5'd0;
      data_p1  <= '0;
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      vld_p1 <= 1'b0;
      if (hs) begin
        reg_p1  <= win_reg;
        data_p1 <= win_data;
        // Writes to register 0 complete the handshake but never reach the file.
        vld_p1  <= (win_reg != 5'd0);
        if ((win_reg != 5'd0) && !busy_q[win_reg]) begin
          sb_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.regWrite  = vld_p1;
  assign bus.W_reg     = reg_p1;
  assign bus.W_data    = data_p1;
  assign bus.iss_stall = stall;
  assign bus.busy_vec  = busy_q;
  assign bus.sb_err    = sb_err_q;

endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter: directed and randomized bench for regwb_arbiter with a
// behavioural reference of the write-back port and register scoreboard.
module tb_regwb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regwb_if #(.NREG(32), .DW(32)) bus ();

  regwb_arbiter #(.NREG(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] busy_m;
  logic        rw_m;
  logic [4:0]  wreg_m;
  logic [31:0] wdata_m;
  logic        sb_m;
  logic        lastb_m;
  // Outcome of the most recent cycle
  logic        ga_last;
  logic        gb_last;
  logic        stall_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_m  = '0;
    rw_m    = 1'b0;
    wreg_m  = '0;
    wdata_m = '0;
    sb_m    = 1'b0;
    lastb_m = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 0; bus.a_reg = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_reg = 0; bus.b_data = 0;
    bus.iss_valid = 0; bus.iss_dst = 0; bus.iss_src1 = 0; bus.iss_src2 = 0;
  endtask

  // Called just after a rising edge; releases reset before the next falling edge.
  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    model_reset();
    rst = 1'b1;
  endtask

  function automatic logic is_busy(input logic [4:0] r);
    return (r != 0) && busy_m[r];
  endfunction

  // One clock: check everything at the falling edge, then advance the model
  // at the rising edge. Returns 1 ns after the rising edge.
  task automatic cycle();
    logic ea, eb, es, a_tie;
    logic [4:0] r;
    logic [31:0] d, nb;
    @(negedge clk);
`ifdef WB_RR_EN
    a_tie = lastb_m;
`else
    a_tie = 1'b0;
`endif
    ea = bus.a_valid && (!bus.b_valid || a_tie);
    eb = bus.b_valid && !ea;
    es = bus.iss_valid && (is_busy(bus.iss_src1) || is_busy(bus.iss_src2) || is_busy(bus.iss_dst));
    chk("a_ready", bus.a_ready, ea);
    chk("b_ready", bus.b_ready, eb);
    chk("iss_stall", bus.iss_stall, es);
    chk("regWrite", bus.regWrite, rw_m);
    chk("W_reg", bus.W_reg, wreg_m);
    chk("W_data", bus.W_data, wdata_m);
    chk("busy_vec", bus.busy_vec, busy_m);
    chk("sb_err", bus.sb_err, sb_m);
    ga_last = ea; gb_last = eb; stall_last = es;
    @(posedge clk);
    nb = busy_m;
    if (rw_m) nb[wreg_m] = 1'b0;
    if (bus.iss_valid && !es && bus.iss_dst != 0) nb[bus.iss_dst] = 1'b1;
    if (ea || eb) begin
      r = ea ? bus.a_reg : bus.b_reg;
      d = ea ? bus.a_data : bus.b_data;
      if (r != 0 && !busy_m[r]) sb_m = 1'b1;
      wreg_m = r; wdata_m = d; rw_m = (r != 0);
      lastb_m = eb;
    end else begin
      rw_m = 1'b0;
    end
    busy_m = nb;
    #1;
  endtask

  initial begin
    logic [3:0]  gpat;
    logic [31:0] busy_before;
    idle_inputs();
    model_reset();
    #12;
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset state followed by a single A write
    bus.a_valid = 1; bus.a_reg = 5; bus.a_data = 32'hDEADBEEF;
    cycle();
    chk("t1_a_ready", ga_last, 1'b1);
    bus.a_valid = 0;
    chk("t1_regWrite", bus.regWrite, 1'b1);
    chk("t1_W_reg", bus.W_reg, 32'd5);
    chk("t1_W_data", bus.W_data, 32'hDEADBEEF);
    cycle();
    chk("t1_regWrite_drop", bus.regWrite, 1'b0);
    cycle();

    // Contention: both requesters valid for four cycles
    apply_reset();
    bus.a_valid = 1; bus.a_reg = 1; bus.a_data = 32'hA1A1A1A1;
    bus.b_valid = 1; bus.b_reg = 2; bus.b_data = 32'hB2B2B2B2;
    gpat = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      gpat = {gpat[2:0], ga_last};
      chk("cont_regWrite", bus.regWrite, 1'b1);
    end
`ifdef WB_RR_EN
    chk("cont_grants", gpat, 4'b1010);
`else
    chk("cont_grants", gpat, 4'b0000);
`endif
    idle_inputs();
    cycle();

    // RAW stall released by a load write
    apply_reset();
    bus.iss_valid = 1; bus.iss_dst = 7;
    cycle();
    bus.iss_dst = 0; bus.iss_src1 = 7;
    bus.b_valid = 1; bus.b_reg = 7; bus.b_data = 32'h0000_0777;
    cycle();
    chk("raw_stall_0", stall_last, 1'b1);
    bus.b_valid = 0;
    cycle();
    chk("raw_stall_1", stall_last, 1'b1);
    cycle();
    chk("raw_stall_2", stall_last, 1'b0);
    idle_inputs();

    // Register 0
    bus.a_valid = 1; bus.a_reg = 0; bus.a_data = 32'h1234;
    cycle();
    chk("r0_a_ready", ga_last, 1'b1);
    bus.a_valid = 0;
    chk("r0_regWrite", bus.regWrite, 1'b0);
    busy_before = bus.busy_vec;
    bus.iss_valid = 1; bus.iss_dst = 0; bus.iss_src1 = 0; bus.iss_src2 = 0;
    cycle();
    chk("r0_stall", stall_last, 1'b0);
    chk("r0_busy", bus.busy_vec, busy_before);
    idle_inputs();

    // Stray write to reg 3, then set/clear of reg 9 at the same edge
    apply_reset();
    bus.a_valid = 1; bus.a_reg = 3; bus.a_data = 32'h33;
    cycle();
    bus.a_reg = 9; bus.a_data = 32'h99;
    cycle();
    chk("stray_sb_err", bus.sb_err, 1'b1);
    bus.a_valid = 0;
    bus.iss_valid = 1; bus.iss_dst = 9;
    cycle();
    bus.iss_valid = 0;
    chk("setclr_busy9", bus.busy_vec[9], 1'b1);
    cycle();
    cycle();
    chk("sb_err_held", bus.sb_err, 1'b1);

    // Asynchronous reset during a regWrite cycle
    apply_reset();
    bus.iss_valid = 1; bus.iss_dst = 7;
    cycle();
    bus.iss_valid = 0;
    bus.b_valid = 1; bus.b_reg = 7; bus.b_data = 32'h7070;
    cycle();
    bus.b_valid = 0;
    chk("ar_pre_regWrite", bus.regWrite, 1'b1);
    chk("ar_pre_busy", bus.busy_vec, 32'h0000_0080);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_regWrite", bus.regWrite, 1'b0);
    chk("ar_busy", bus.busy_vec, 32'h0);
    chk("ar_sb_err", bus.sb_err, 1'b0);
    model_reset();
    #1;
    rst = 1'b1;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!(bus.a_valid && !ga_last)) begin
        bus.a_valid = ($urandom_range(0, 2) != 0);
        bus.a_reg   = 5'($urandom_range(0, 12));
        bus.a_data  = $urandom;
      end
      if (!(bus.b_valid && !gb_last)) begin
        bus.b_valid = ($urandom_range(0, 2) != 0);
        bus.b_reg   = 5'($urandom_range(0, 12));
        bus.b_data  = $urandom;
      end
      bus.iss_valid = ($urandom_range(0, 1) != 0);
      bus.iss_dst   = 5'($urandom_range(0, 12));
      bus.iss_src1  = 5'($urandom_range(0, 12));
      bus.iss_src2  = 5'($urandom_range(0, 12));
      cycle();
    end
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
